// File: rtl/button_event_ctrl_pkg.sv
// Shared definitions for the button event controller: channel FSM encoding
// and counter sizing helpers.
package button_event_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    HELD = 2'd2
  } btn_state_e;

  // ceil(log2(value)), returning 0 for value <= 1
  function automatic int clog2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    while (v > 0) begin
      w = w + 1;
      v = v >>> 1;
    end
    return w;
  endfunction

  // Width of a counter that must hold 0..max_count (at least 1 bit)
  function automatic int cnt_w(input int max_count);
    int w;
    w = clog2(max_count + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_event_ctrl_if.sv
// Button bundle: raw levels in, debounced levels and per-channel event pulses out.
interface button_event_ctrl_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn;
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] release_pulse;
  logic [N_BTN-1:0] long_press;
  logic [N_BTN-1:0] repeat_pulse;

  modport master (
    output btn,
    input  level, press, release_pulse, long_press, repeat_pulse
  );

  modport slave (
    input  btn,
    output level, press, release_pulse, long_press, repeat_pulse
  );
endinterface

// File: rtl/button_event_ctrl_channel.sv
// One button channel: lockout debounce FSM with long-press and auto-repeat
// timing, all counting in shared ticks.
module button_channel
  import button_event_ctrl_pkg::*;
#(
  parameter int LOCK_TICKS   = 10,
  parameter int LONG_TICKS   = 25,
  parameter int REPEAT_TICKS = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic s,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int LW = cnt_w(LOCK_TICKS);
  localparam int HW = cnt_w(LONG_TICKS);
  localparam int RW = cnt_w(REPEAT_TICKS);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_TICKS - 1);

  btn_state_e    state, state_n;
  logic [LW-1:0] lock_cnt, lock_cnt_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic [RW-1:0] rep_cnt, rep_cnt_n;
  logic          level_n, press_n, release_n, long_n, repeat_n;
  logic          flip;

  always_comb begin
    state_n    = state;
    lock_cnt_n = lock_cnt;
    hold_cnt_n = hold_cnt;
    rep_cnt_n  = rep_cnt;
    level_n    = level;
    press_n    = 1'b0;
    release_n  = 1'b0;
    long_n     = 1'b0;
    repeat_n   = 1'b0;
    flip       = 1'b0;

    unique case (state)
      IDLE, HELD: begin
        if (s != level) begin
          flip = 1'b1;
        end else if (state == HELD && tick) begin
          // Hold count saturates at the threshold; the repeat phase then runs on its own modulo counter
          if (hold_cnt != HOLD_MAX) begin
            hold_cnt_n = hold_cnt + 1'b1;
            long_n     = (hold_cnt == HOLD_LAST);
          end else if (rep_cnt == REP_LAST) begin
            rep_cnt_n = '0;
            repeat_n  = 1'b1;
          end else begin
            rep_cnt_n = rep_cnt + 1'b1;
          end
        end
      end
      LOCK: begin
        if (tick) begin
          if (lock_cnt == LOCK_LAST) begin
            if (s == level) state_n = level ? HELD : IDLE;
            else            flip    = 1'b1;
          end else begin
            lock_cnt_n = lock_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Any accepted level change restarts lockout and discards hold progress
    if (flip) begin
      state_n    = LOCK;
      level_n    = ~level;
      press_n    = ~level;
      release_n  = level;
      lock_cnt_n = '0;
      hold_cnt_n = '0;
      rep_cnt_n  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      lock_cnt      <= '0;
      hold_cnt      <= '0;
      rep_cnt       <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state         <= state_n;
      lock_cnt      <= lock_cnt_n;
      hold_cnt      <= hold_cnt_n;
      rep_cnt       <= rep_cnt_n;
      level         <= level_n;
      press         <= press_n;
      release_pulse <= release_n;
      long_press    <= long_n;
      repeat_pulse  <= repeat_n;
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Multi-channel button controller: synchronizes raw buttons, generates the
// shared timing tick and runs one independent event channel per button.
module button_event_ctrl
  import button_event_ctrl_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 4,
  parameter int LOCK_TICKS   = 10,
  parameter int LONG_TICKS   = 25,
  parameter int REPEAT_TICKS = 5
) (
  input  logic               clk,
  input  logic               reset,
  button_event_ctrl_if.slave bus
);

  localparam int TW = cnt_w(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [N_BTN-1:0] sync_a, sync_b;
  logic [N_BTN-1:0] level_v, press_v, release_v, long_v, repeat_v;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      sync_a   <= '0;
      sync_b   <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      sync_a   <= bus.btn;
      sync_b   <= sync_a;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .LOCK_TICKS  (LOCK_TICKS),
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .s            (sync_b[i]),
      .level        (level_v[i]),
      .press        (press_v[i]),
      .release_pulse(release_v[i]),
      .long_press   (long_v[i]),
      .repeat_pulse (repeat_v[i])
    );
  end

  assign bus.level         = level_v;
  assign bus.press         = press_v;
  assign bus.release_pulse = release_v;
  assign bus.long_press    = long_v;
  assign bus.repeat_pulse  = repeat_v;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl: expected events are queued when
// stimulus is driven and matched cycle by cycle against the DUT outputs.
module tb_button_event_ctrl;
  localparam int N_BTN        = 4;
  localparam int TICK_DIV     = 4;
  localparam int LOCK_TICKS   = 10;
  localparam int LONG_TICKS   = 25;
  localparam int REPEAT_TICKS = 5;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;
  localparam int K_REPEAT  = 3;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  button_event_ctrl_if #(.N_BTN(N_BTN)) bus ();

  button_event_ctrl #(
    .N_BTN       (N_BTN),
    .TICK_DIV    (TICK_DIV),
    .LOCK_TICKS  (LOCK_TICKS),
    .LONG_TICKS  (LONG_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial forever #5 clk = ~clk;

  ev_t              sb[$];
  int               cyc;
  int               n_assert;
  int               n_fail;
  logic [N_BTN-1:0] exp_level;

  // First tick cycle at or after cycle c (tick when cycle % TICK_DIV == TICK_DIV-1)
  function automatic int next_tick(input int c);
    int k;
    k = c;
    while (k % TICK_DIV != TICK_DIV - 1) k++;
    return k;
  endfunction

  // Cycle where the lockout recheck result is visible, lockout entered (visible) at p
  function automatic int recheck_at(input int p);
    return next_tick(p) + (LOCK_TICKS - 1) * TICK_DIV + 1;
  endfunction

  // Cycle where long_press is visible, HELD entered (visible) at h
  function automatic int long_at(input int h);
    return next_tick(h) + (LONG_TICKS - 1) * TICK_DIV + 1;
  endfunction

  task automatic push(input int c, input int ch, input int kind);
    ev_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = kind;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [N_BTN-1:0] obs, input logic [N_BTN-1:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_level"},   bus.level,         '0);
    chk({tag, "_press"},   bus.press,         '0);
    chk({tag, "_release"}, bus.release_pulse, '0);
    chk({tag, "_long"},    bus.long_press,    '0);
    chk({tag, "_repeat"},  bus.repeat_pulse,  '0);
  endtask

  task automatic check_queue_empty(input string tag);
    n_assert++;
    assert (sb.size() == 0)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d pending expected=0 pending", tag, sb.size());
    end
  endtask

  // Advance one cycle and compare every output against the events due now
  task automatic step();
    logic [N_BTN-1:0] ep, er, el, eq;
    @(negedge clk);
    cyc++;
    ep = '0; er = '0; el = '0; eq = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          K_PRESS:   ep[sb[i].ch] = 1'b1;
          K_RELEASE: er[sb[i].ch] = 1'b1;
          K_LONG:    el[sb[i].ch] = 1'b1;
          default:   eq[sb[i].ch] = 1'b1;
        endcase
        sb.delete(i);
      end
    end
    exp_level = (exp_level | ep) & ~er;
    chk("level",      bus.level,         exp_level);
    chk("press",      bus.press,         ep);
    chk("release",    bus.release_pulse, er);
    chk("long_press", bus.long_press,    el);
    chk("repeat",     bus.repeat_pulse,  eq);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int c, p, h, lp;
    n_assert  = 0;
    n_fail    = 0;
    cyc       = 0;
    exp_level = '0;
    bus.btn   = '0;
    reset     = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset_state");
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;

    // Clean press on channel 0, held 60 cycles then released
    run(5);
    c = cyc;
    bus.btn[0] = 1'b1;
    push(c + 3, 0, K_PRESS);
    run(60);
    bus.btn[0] = 1'b0;
    push(c + 63, 0, K_RELEASE);
    run(60);

    // Bounce on channel 1 during lockout, settling low
    c = cyc;
    bus.btn[1] = 1'b1;
    push(c + 3, 1, K_PRESS);
    push(recheck_at(c + 3), 1, K_RELEASE);
    run(10);
    bus.btn[1] = 1'b0;
    run(10);
    bus.btn[1] = 1'b1;
    run(10);
    bus.btn[1] = 1'b0;
    run(70);

    // Long hold on channel 2 for 200 ticks
    c  = cyc;
    p  = c + 3;
    h  = recheck_at(p);
    lp = long_at(h);
    bus.btn[2] = 1'b1;
    push(p, 2, K_PRESS);
    push(lp, 2, K_LONG);
    for (int v = lp + REPEAT_TICKS * TICK_DIV; v <= c + 802; v += REPEAT_TICKS * TICK_DIV)
      push(v, 2, K_REPEAT);
    run(800);
    bus.btn[2] = 1'b0;
    push(c + 803, 2, K_RELEASE);
    run(60);

    // Simultaneous press on all channels, staggered releases
    c = cyc;
    bus.btn = '1;
    for (int i = 0; i < N_BTN; i++) push(c + 3, i, K_PRESS);
    run(50);
    bus.btn[3] = 1'b0;
    push(c + 53, 3, K_RELEASE);
    run(10);
    bus.btn[0] = 1'b0;
    push(c + 63, 0, K_RELEASE);
    run(10);
    bus.btn[1] = 1'b0;
    push(c + 73, 1, K_RELEASE);
    run(10);
    bus.btn[2] = 1'b0;
    push(c + 83, 2, K_RELEASE);
    run(60);

    // Synchronized edge lands in a tick cycle; recheck must be a full lockout later
    while (cyc % TICK_DIV != 1) step();
    c = cyc;
    bus.btn[3] = 1'b1;
    push(c + 3, 3, K_PRESS);
    run(10);
    bus.btn[3] = 1'b0;
    push(c + 3 + LOCK_TICKS * TICK_DIV, 3, K_RELEASE);
    run(90);

    // Reset while channel 0 is held
    check_queue_empty("queue_before_reset");
    c = cyc;
    bus.btn[0] = 1'b1;
    push(c + 3, 0, K_PRESS);
    run(60);
    reset     = 1'b1;
    exp_level = '0;
    #1;
    check_outputs_zero("reset_mid_held");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
    push(3, 0, K_PRESS);
    run(50);
    bus.btn[0] = 1'b0;
    push(53, 0, K_RELEASE);
    run(60);

    check_queue_empty("queue_at_end");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
